// File: rtl/dht11_frame_rx_if.sv
// Sensor-side bundle for dht11_frame_rx: line/enable inputs, status strobes, decoded bytes and stats.
// master = receiver block, slave = sequencing controller / display consumer.
interface dht11_frame_rx_if;
    logic        rx_en;
    logic        dht_in;
    logic        busy;
    logic [5:0]  bit_cnt;
    logic        frame_valid;
    logic        chk_err;
    logic        timeout_err;
    logic [7:0]  hum_int;
    logic [7:0]  hum_dec;
    logic [7:0]  tmp_int;
    logic [7:0]  tmp_dec;
    logic [15:0] good_cnt;
    logic [15:0] err_cnt;

    modport master (
        input  rx_en, dht_in,
        output busy, bit_cnt, frame_valid, chk_err, timeout_err,
               hum_int, hum_dec, tmp_int, tmp_dec, good_cnt, err_cnt
    );

    modport slave (
        output rx_en, dht_in,
        input  busy, bit_cnt, frame_valid, chk_err, timeout_err,
               hum_int, hum_dec, tmp_int, tmp_dec, good_cnt, err_cnt
    );
endinterface

// File: rtl/dht11_frame_rx.sv
// DHT11 single-wire frame receiver: times response/data pulses, decodes 40 bits, verifies checksum.
// Optional good/error frame counters are enabled by defining DHT_FRAME_RX_STATS_EN.
module dht11_frame_rx #(
    parameter int CLK_FREQ_HZ   = 100_000_000,
    parameter int BIT_THRESH_US = 50,
    parameter int TIMEOUT_US    = 255
) (
    input  logic             clk,
    input  logic             rst,
    dht11_frame_rx_if.master bus
);
    localparam int DIV = (CLK_FREQ_HZ / 1_000_000 < 1) ? 1 : CLK_FREQ_HZ / 1_000_000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RESP_LOW,
        RESP_HIGH,
        BIT_LOW,
        BIT_HIGH,
        CHECK
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_cnt;
    logic          tick;
    logic          sync1, sync2, sync3;
    logic          rise, fall;
    logic [7:0]    width;
    logic [39:0]   shreg;
    logic [5:0]    bit_cnt_q;
    logic          start, shift_en, good, bad, tmo, bit_val;
    logic [7:0]    sum;
    logic          fv_q, ce_q, te_q;
    logic [7:0]    hi_q, hd_q, ti_q, td_q;

    assign tick = (pre_cnt == PW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       pre_cnt <= '0;
        else if (tick) pre_cnt <= '0;
        else           pre_cnt <= pre_cnt + 1'b1;
    end

    // Synchronisers reset to the idle (pulled-up) level so reset release is not seen as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
        end else begin
            sync1 <= bus.dht_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise = sync2 & ~sync3;
    assign fall = ~sync2 & sync3;
    assign sum  = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];

    // Counting the tick of the closing cycle makes the measured width exact in whole microseconds.
    assign bit_val = ({1'b0, width} + {8'd0, tick}) > 9'(BIT_THRESH_US);

    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        shift_en = 1'b0;
        good     = 1'b0;
        bad      = 1'b0;
        tmo      = 1'b0;
        if (state_q == IDLE) begin
            if (bus.rx_en && !sync2) begin
                state_d = RESP_LOW;
                start   = 1'b1;
            end
        end else if (!bus.rx_en) begin
            state_d = IDLE;
        end else if (width >= 8'(TIMEOUT_US)) begin
            state_d = IDLE;
            tmo     = 1'b1;
        end else begin
            case (state_q)
                RESP_LOW:  if (rise) state_d = RESP_HIGH;
                RESP_HIGH: if (fall) state_d = BIT_LOW;
                BIT_LOW:   if (rise) state_d = BIT_HIGH;
                BIT_HIGH: begin
                    if (fall) begin
                        shift_en = 1'b1;
                        state_d  = (bit_cnt_q == 6'd39) ? CHECK : BIT_LOW;
                    end
                end
                CHECK: begin
                    state_d = IDLE;
                    if (sum == shreg[7:0]) good = 1'b1;
                    else                   bad  = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            width     <= '0;
            shreg     <= '0;
            bit_cnt_q <= '0;
            fv_q      <= 1'b0;
            ce_q      <= 1'b0;
            te_q      <= 1'b0;
            hi_q      <= '0;
            hd_q      <= '0;
            ti_q      <= '0;
            td_q      <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)           width <= '0;
            else if (tick && width != 8'hFF)  width <= width + 8'd1;
            if (start) begin
                bit_cnt_q <= '0;
                shreg     <= '0;
            end else if (shift_en) begin
                bit_cnt_q <= bit_cnt_q + 6'd1;
                shreg     <= {shreg[38:0], bit_val};
            end
            fv_q <= good;
            ce_q <= bad;
            te_q <= tmo;
            if (good) begin
                hi_q <= shreg[39:32];
                hd_q <= shreg[31:24];
                ti_q <= shreg[23:16];
                td_q <= shreg[15:8];
            end
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.bit_cnt     = bit_cnt_q;
    assign bus.frame_valid = fv_q;
    assign bus.chk_err     = ce_q;
    assign bus.timeout_err = te_q;
    assign bus.hum_int     = hi_q;
    assign bus.hum_dec     = hd_q;
    assign bus.tmp_int     = ti_q;
    assign bus.tmp_dec     = td_q;

`ifdef DHT_FRAME_RX_STATS_EN
    logic [15:0] good_cnt_q, err_cnt_q;

    // Counters move on the same edge that raises the matching strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            good_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (good && good_cnt_q != 16'hFFFF)
                good_cnt_q <= good_cnt_q + 16'd1;
            if ((bad || tmo) && err_cnt_q != 16'hFFFF)
                err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign bus.good_cnt = good_cnt_q;
    assign bus.err_cnt  = err_cnt_q;
`else
    assign bus.good_cnt = 16'd0;
    assign bus.err_cnt  = 16'd0;
`endif
endmodule

// File: tb/tb_dht11_frame_rx.sv
// Scoreboard bench for dht11_frame_rx: synthetic sensor waveforms, expected strobes queued and
// compared as the receiver reports them. Runs with a 2 MHz-equivalent divisor to keep frames short.
module tb_dht11_frame_rx;
    localparam int CLK_HZ = 2_000_000;
    localparam int DIV    = CLK_HZ / 1_000_000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dht11_frame_rx_if bus();

    dht11_frame_rx #(
        .CLK_FREQ_HZ  (CLK_HZ),
        .BIT_THRESH_US(50),
        .TIMEOUT_US   (255)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;
        logic [7:0] hi, hd, ti, td;
    } exp_t;

    exp_t       sb[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         last_strobe_cyc = 0;
    int         obs_kind;
    exp_t       mon_e;
    logic [7:0] m_hi = 8'd0, m_hd = 8'd0, m_ti = 8'd0, m_td = 8'd0;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic waitUs(input int us);
        repeat (us * DIV) @(negedge clk);
    endtask

    task automatic waitDrain(input int max_us);
        int n = 0;
        while (sb.size() != 0 && n < max_us * DIV) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput("scoreboard_drained", sb.size(), 0);
    endtask

    task automatic pushExpect(input int kind);
        exp_t e;
        e.kind = kind;
        e.hi   = m_hi;
        e.hd   = m_hd;
        e.ti   = m_ti;
        e.td   = m_td;
        sb.push_back(e);
    endtask

    // Drives response + n_bits data bits; only complete frames queue an expected strobe.
    task automatic applyStimulus(input logic [39:0] frame, input int n_bits,
                                 input int one_us, input int zero_us);
        logic [7:0] s;
        if (n_bits == 40) begin
            s = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
            if (s == frame[7:0]) begin
                m_hi = frame[39:32];
                m_hd = frame[31:24];
                m_ti = frame[23:16];
                m_td = frame[15:8];
                pushExpect(0);
            end else begin
                pushExpect(1);
            end
        end
        bus.rx_en  = 1'b1;
        bus.dht_in = 1'b1;
        waitUs(5);
        bus.dht_in = 1'b0;
        waitUs(80);
        bus.dht_in = 1'b1;
        waitUs(80);
        for (int i = 0; i < n_bits; i++) begin
            bus.dht_in = 1'b0;
            waitUs(50);
            bus.dht_in = 1'b1;
            waitUs(frame[39-i] ? one_us : zero_us);
        end
        bus.dht_in = 1'b0;
        if (n_bits == 40) begin
            waitUs(50);
            bus.dht_in = 1'b1;
            waitUs(5);
            bus.rx_en = 1'b0;
            waitUs(5);
        end else begin
            waitUs(10);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"},     bus.busy, 0);
        checkOutput({tag, "_bit_cnt"},  bus.bit_cnt, 0);
        checkOutput({tag, "_strobes"},  {bus.frame_valid, bus.chk_err, bus.timeout_err}, 0);
        checkOutput({tag, "_hum_int"},  bus.hum_int, 0);
        checkOutput({tag, "_hum_dec"},  bus.hum_dec, 0);
        checkOutput({tag, "_tmp_int"},  bus.tmp_int, 0);
        checkOutput({tag, "_tmp_dec"},  bus.tmp_dec, 0);
        checkOutput({tag, "_good_cnt"}, bus.good_cnt, 0);
        checkOutput({tag, "_err_cnt"},  bus.err_cnt, 0);
    endtask

    // Every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && (bus.frame_valid || bus.chk_err || bus.timeout_err)) begin
            last_strobe_cyc = cyc;
            obs_kind = bus.frame_valid ? 0 : (bus.chk_err ? 1 : 2);
            checkOutput("strobe_onehot",
                        32'(bus.frame_valid) + 32'(bus.chk_err) + 32'(bus.timeout_err), 1);
            if (sb.size() == 0) begin
                checkOutput("unexpected_strobe", obs_kind, 32'hDEAD);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("strobe_kind", obs_kind, mon_e.kind);
                checkOutput("hum_int", bus.hum_int, mon_e.hi);
                checkOutput("hum_dec", bus.hum_dec, mon_e.hd);
                checkOutput("tmp_int", bus.tmp_int, mon_e.ti);
                checkOutput("tmp_dec", bus.tmp_dec, mon_e.td);
                checkOutput("busy_at_strobe", bus.busy, 0);
                if (mon_e.kind != 2)
                    checkOutput("bit_cnt_at_strobe", bus.bit_cnt, 40);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int fall_cyc;
        int lat;
        bus.rx_en  = 1'b0;
        bus.dht_in = 1'b1;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        waitUs(5);

        $display("[TB] good frame 37/00/18/00");
        applyStimulus(40'h37_00_18_00_4F, 40, 70, 26);
        waitDrain(100);

        $display("[TB] bad checksum frame");
        applyStimulus(40'h37_00_18_00_50, 40, 70, 26);
        waitDrain(100);

        $display("[TB] line stuck low");
        pushExpect(2);
        bus.rx_en = 1'b1;
        waitUs(5);
        fall_cyc = cyc;
        bus.dht_in = 1'b0;
        waitDrain(300);
        lat = last_strobe_cyc - fall_cyc;
        checkOutput("timeout_latency", (lat >= 254 * DIV) && (lat <= 260 * DIV), 1);
        bus.rx_en  = 1'b0;
        bus.dht_in = 1'b1;
        waitUs(10);

        $display("[TB] abort after bit 20 then full frame");
        applyStimulus(40'h2A_05_17_03_49, 20, 70, 26);
        checkOutput("bit_cnt_at_abort", bus.bit_cnt, 20);
        checkOutput("busy_before_abort", bus.busy, 1);
        bus.rx_en = 1'b0;
        @(negedge clk);
        checkOutput("busy_after_abort", bus.busy, 0);
        bus.dht_in = 1'b1;
        waitUs(20);
        applyStimulus(40'h2A_05_17_03_49, 40, 70, 26);
        waitDrain(100);

        $display("[TB] threshold frame, 51 us ones and 50 us zeros");
        applyStimulus(40'h55_0A_21_03_83, 40, 51, 50);
        waitDrain(100);

`ifdef DHT_FRAME_RX_STATS_EN
        checkOutput("good_cnt", bus.good_cnt, 3);
        checkOutput("err_cnt",  bus.err_cnt, 2);
`else
        checkOutput("good_cnt", bus.good_cnt, 0);
        checkOutput("err_cnt",  bus.err_cnt, 0);
`endif

        $display("[TB] reset mid-frame");
        applyStimulus(40'h12_34_56_78_14, 12, 70, 26);
        checkOutput("busy_before_reset", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        checkAllZero("midreset");
        bus.rx_en  = 1'b0;
        bus.dht_in = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        waitUs(5);
        checkOutput("busy_after_reset", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
